// File: rtl/reg_file_inc.sv
// Shared types and constants for the RV32 integer register file.
package reg_file_pkg;

  localparam int XLEN              = 32;
  localparam int REG_FILE_NUM_REGS = 32;
  localparam int REG_ADDR_W        = 5;

  localparam logic [REG_ADDR_W-1:0] REGISTER_X0 = '0;

  // Read request as produced by decode.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } reg_file_read_params_t;

  // Writeback port bundled for internal use.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } reg_file_write_params_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: tracks registers with an outstanding writeback
// and flags RAW (per source) and WAW hazards for the request being offered.
module reg_file_scoreboard
  import reg_file_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_idx_i,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  rd_en_i,
  output logic                  rs1_haz_o,
  output logic                  rs2_haz_o,
  output logic                  waw_haz_o
);

  logic [REG_FILE_NUM_REGS-1:0] pending_q, pending_d;

  // Next pending vector: writeback clears first so a same-cycle set wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid_i && wb_rd_i != REGISTER_X0) pending_d[wb_rd_i] = 1'b0;
    if (set_en_i && set_idx_i != REGISTER_X0) pending_d[set_idx_i] = 1'b1;
    if (flush_i) pending_d = '0;
    pending_d[0] = 1'b0;
  end

  // Pending vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // A pending register whose writeback arrives this cycle is no longer a hazard.
  always_comb begin
    rs1_haz_o = pending_q[rs1_i] && !(wb_valid_i && wb_rd_i == rs1_i);
    rs2_haz_o = pending_q[rs2_i] && !(wb_valid_i && wb_rd_i == rs2_i);
    waw_haz_o = rd_en_i && pending_q[rd_i] && !(wb_valid_i && wb_rd_i == rd_i);
  end

endmodule

// File: rtl/reg_file.sv
// RV32 architectural register file: x1..x31 storage, writeback bypass to the
// read ports, registered operands one cycle after accept, and hazard stalls.
module reg_file
  import reg_file_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  reg_file_read_params_t req_params,
  input  logic                  req_rd_en,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush
);

  reg_file_write_params_t wb;
  logic [XLEN-1:0] regs_q [1:REG_FILE_NUM_REGS-1];
  logic [XLEN-1:0] rs1_data_q, rs2_data_q, rs1_data_d, rs2_data_d;
  logic            rsp_valid_q;
  logic            rs1_haz, rs2_haz, waw_haz;
  logic            accept;

  assign wb.valid = wb_valid;
  assign wb.rd    = wb_rd;
  assign wb.data  = wb_data;

  reg_file_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .set_en_i   (accept && req_rd_en),
    .set_idx_i  (req_params.rd),
    .wb_valid_i (wb.valid),
    .wb_rd_i    (wb.rd),
    .rs1_i      (req_params.rs1),
    .rs2_i      (req_params.rs2),
    .rd_i       (req_params.rd),
    .rd_en_i    (req_rd_en),
    .rs1_haz_o  (rs1_haz),
    .rs2_haz_o  (rs2_haz),
    .waw_haz_o  (waw_haz)
  );

  // Ready is independent of req_valid so decode can look ahead.
  always_comb begin
    req_ready = rst_n && !flush && !(rs1_haz || rs2_haz || waw_haz);
    accept    = req_valid && req_ready;
  end

  // Operand select: x0 reads zero, same-cycle writeback beats storage.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [REG_ADDR_W-1:0] rs,
    input reg_file_write_params_t w,
    input logic [XLEN-1:0]       stored
  );
    if (rs == REGISTER_X0)           return '0;
    else if (w.valid && w.rd == rs)  return w.data;
    else                             return stored;
  endfunction

  // Operand muxes; the storage index is only used when rs is non-zero.
  always_comb begin
    rs1_data_d = sel_operand(req_params.rs1, wb,
                             (req_params.rs1 == REGISTER_X0) ? '0 : regs_q[req_params.rs1]);
    rs2_data_d = sel_operand(req_params.rs2, wb,
                             (req_params.rs2 == REGISTER_X0) ? '0 : regs_q[req_params.rs2]);
  end

  // Register storage; writes to x0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < REG_FILE_NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wb.valid && wb.rd != REGISTER_X0) begin
      regs_q[wb.rd] <= wb.data;
    end
  end

  // Response registers: operands hold when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rs1_data_q <= rs1_data_d;
        rs2_data_q <= rs2_data_d;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rs1_data  = rs1_data_q;
  assign rs2_data  = rs2_data_q;

endmodule

// File: doc/reg_file.md
# reg_file

Architectural integer register file for the RV32 core, the responder for the read parameters produced by the decode stage. It accepts `reg_file_read_params_t` requests (rd, rs1, rs2), returns registered rs1/rs2 operand data one cycle later, and accepts one writeback per cycle. A pending-write scoreboard stalls issue on RAW/WAW hazards, and same-cycle writeback data is bypassed to the read ports.

## Interface
- `XLEN`, 32, data width of each register.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  decode presents a read request.
- `req_params`  in  reg_file_read_params_t  rd, rs1, rs2 (5 bits each).
- `req_rd_en`  in  1  instruction will write rd; marks rd pending on accept.
- `req_ready`  out  1  request accepted this cycle when `req_valid && req_ready`.
- `rsp_valid`  out  1  operands valid; one cycle after accept.
- `rs1_data`  out  XLEN  operand for rs1.
- `rs2_data`  out  XLEN  operand for rs2.
- `wb_valid`  in  1  writeback strobe.
- `wb_rd`  in  5  writeback destination.
- `wb_data`  in  XLEN  writeback value.
- `flush`  in  1  pipeline flush; clears scoreboard and in-flight response.

## Operation
- Storage: x1..x31, XLEN bits each. x0 is not stored, always reads 0, ignores writes, and is never marked pending.
- Write: when `wb_valid && wb_rd != 0`, the register is written at the clock edge and its pending bit is cleared.
- Scoreboard: 32-bit pending vector, bit 0 tied to 0. On accept with `req_rd_en && rd != 0`, the rd bit is set.
- Same-cycle set and clear of the same index (accept sets X, wb clears X): set wins, bit stays 1.
- Hazard for source rsN (N=1,2): `pending[rsN] && !(wb_valid && wb_rd == rsN)`.
- Hazard for the WAW case: `req_rd_en && pending[rd] && !(wb_valid && wb_rd == rd)`.
- `req_ready = !flush && !(rs1 hazard || rs2 hazard || WAW hazard)`. It is a function of the current inputs and state only and does not depend on `req_valid`.
- Operand select on accept, per port:
  - rsN == 0 → 0.
  - else `wb_valid && wb_rd == rsN` → `wb_data` (bypass).
  - else the stored value.
- The selected operands are registered into `rsN_data`, and `rsp_valid` is set for one cycle.
- With no accept, `rsN_data` hold their last value and `rsp_valid` = 0.
- Flush: pending vector cleared, `rsp_valid` forced 0 next cycle, no request accepted that cycle. A writeback in the same cycle still updates the register.
- Upstream forces rs1 to x0 for LUI/CSRxI, so those requests never hazard on rs1.

## Timing
- Reset (async assert, sync-safe deassert): all registers 0, pending 0, `rsp_valid` 0, `rs1_data`/`rs2_data` 0.
- `req_ready` is low while `rst_n` is low.
- Read latency: 1 cycle from accept to `rsp_valid`. Back-to-back accepts give `rsp_valid` high on consecutive cycles.
- A write at edge T is visible through storage from T onward, and visible via bypass in the cycle ending at T.
- Stall: a request with a hazard is held by decode (params stable, `req_valid` high) until `req_ready`. It is not accepted while stalled.
- Reset mid-operation: scoreboard and outputs return to reset values immediately. In-flight writebacks are lost.

## Structure
- `reg_file_inc.sv` keeps `reg_file_read_params_t` and `REGISTER_X0`.
- Add to `reg_file_inc.sv`:
  - `reg_file_write_params_t` with fields `valid`, `rd`, `data`.
  - `REG_FILE_NUM_REGS` = 32.
  - `REG_ADDR_W` = 5.
- One sub-module, `reg_file_scoreboard`: pending vector, set/clear/flush logic, and the three hazard outputs.
- Storage, bypass muxes and output registers stay in `reg_file`.

## Test plan
- Reset, then read rs1=5, rs2=0 → next cycle `rsp_valid`=1, `rs1_data`=0, `rs2_data`=0. Write x0=0xDEAD_BEEF, then read x0 → 0.
- Accept rd=3 with `req_rd_en`=1, then request rs1=3 → `req_ready`=0. Writeback x3=0x1234_5678 in a later cycle → `req_ready`=1 that same cycle, and `rs1_data`=0x1234_5678 the next cycle (bypass).
- Same cycle: writeback clears x7 and accept sets rd=7 → pending[7] stays 1, and a following read of rs1=7 stalls.
- x9 pending, then a request with rd=9, `req_rd_en`=1 → WAW stall until the x9 writeback.
- Set x4 and x6 pending, then assert `flush` → no accept that cycle, pending cleared, and a request for rs1=4/rs2=6 is accepted the next cycle with the old stored values.
- 100 random accept/writeback/flush cycles against a reference model → operands match, no accept with a true hazard, no deadlock.
